// File: rtl/kernel_launch_ctrl.sv
// kernel_launch_ctrl
// Host-facing launch controller placed directly in front of the block dispatcher.
// The host programs a kernel thread count and issues launch / abort / clear_status
// commands through a four-entry register file. The controller then sequences the
// dispatcher: a reset phase (CLEAR), a level start held until the dispatcher reports
// done (RUN), a one-cycle completion phase that raises the interrupt (COMPLETE), or an
// abort phase that holds the dispatcher in reset before returning to IDLE (ABORT).
// A saturating counter records how many cycles the kernel spent in CLEAR and RUN.
//
// Register map (byte wide):
//   0 THREAD_COUNT  read/write, writes ignored while busy
//   1 CONTROL       write-only command strobes: [0] launch [1] abort [2] clear_status
//   2 STATUS        [0] busy [1] done [2] aborted [3] err_busy_write [4] err_zero_threads
//   3 CYCLES        low byte of the kernel cycle counter

module kernel_launch_ctrl #(
  parameter int THREAD_COUNT_BITS = 8,
  parameter int CYCLE_COUNT_BITS  = 32,
  parameter int RESET_CYCLES      = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         reg_write_en,
  input  logic                         reg_read_en,
  input  logic [1:0]                   reg_addr,
  input  logic [7:0]                   reg_write_data,
  output logic [7:0]                   reg_read_data,
  output logic                         reg_read_valid,
  output logic [THREAD_COUNT_BITS-1:0] thread_count,
  output logic                         dispatch_reset,
  output logic                         dispatch_start,
  input  logic                         dispatch_done,
  output logic                         busy,
  output logic                         irq,
  output logic [CYCLE_COUNT_BITS-1:0]  cycle_count
);

  // Register addresses
  localparam logic [1:0] ADDR_THREAD_COUNT = 2'd0;
  localparam logic [1:0] ADDR_CONTROL      = 2'd1;
  localparam logic [1:0] ADDR_STATUS       = 2'd2;
  localparam logic [1:0] ADDR_CYCLES       = 2'd3;

  // CONTROL command bit positions
  localparam int CTRL_LAUNCH = 0;
  localparam int CTRL_ABORT  = 1;
  localparam int CTRL_CLEAR  = 2;

  // Phase counter for the CLEAR and ABORT reset windows: counts 0 .. RESET_CYCLES-1
  localparam int              RC_W    = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [RC_W-1:0] RC_LAST = RC_W'(RESET_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_RUN,
    ST_COMPLETE,
    ST_ABORT
  } state_t;

  state_t                        state_q, state_d;
  logic [RC_W-1:0]               rst_cnt_q, rst_cnt_d;

  logic [THREAD_COUNT_BITS-1:0]  thread_count_q;
  logic [CYCLE_COUNT_BITS-1:0]   cycle_count_q;
  logic                          dispatch_reset_q, dispatch_start_q, busy_q, irq_q;
  logic                          done_q, aborted_q, err_busy_q, err_zero_q;
  logic [7:0]                    read_data_q;
  logic                          read_valid_q;

  // Next-cycle values of the state-derived dispatcher outputs
  logic                          dispatch_reset_d, dispatch_start_d, busy_d, irq_d;

  // Decoded host commands for this cycle
  logic wr_thread_count, wr_control;
  logic cmd_launch, cmd_abort, cmd_clear;
  logic busy_now, thread_count_nonzero;
  logic launch_ok, launch_zero, busy_violation;
  logic enter_complete, enter_abort;
  logic [7:0] status_byte, read_mux;

  assign wr_thread_count      = reg_write_en && (reg_addr == ADDR_THREAD_COUNT);
  assign wr_control           = reg_write_en && (reg_addr == ADDR_CONTROL);
  assign cmd_launch           = wr_control && reg_write_data[CTRL_LAUNCH];
  assign cmd_abort            = wr_control && reg_write_data[CTRL_ABORT];
  assign cmd_clear            = wr_control && reg_write_data[CTRL_CLEAR];
  assign busy_now             = (state_q == ST_CLEAR) || (state_q == ST_RUN) ||
                                (state_q == ST_ABORT);
  assign thread_count_nonzero = (thread_count_q != '0);

  // A launch only counts in IDLE and only when abort is not set in the same write;
  // launch+abort together in IDLE is a no-op.
  assign launch_ok      = (state_q == ST_IDLE) && cmd_launch && !cmd_abort &&  thread_count_nonzero;
  assign launch_zero    = (state_q == ST_IDLE) && cmd_launch && !cmd_abort && !thread_count_nonzero;
  assign busy_violation = busy_now && (wr_thread_count || cmd_launch);

  // Completion beats a simultaneous abort in RUN.
  assign enter_complete = (state_q == ST_RUN) && dispatch_done;
  assign enter_abort    = ((state_q == ST_CLEAR) || (state_q == ST_RUN)) &&
                          cmd_abort && !enter_complete;

  // Next-state logic and next values of the registered dispatcher outputs
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d   = state_q;
    rst_cnt_d = rst_cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (launch_ok) begin
          state_d   = ST_CLEAR;
          rst_cnt_d = '0;
        end
      end
      ST_CLEAR: begin
        if (enter_abort) begin
          state_d   = ST_ABORT;
          rst_cnt_d = '0;
        end else if (rst_cnt_q == RC_LAST) begin
          state_d   = ST_RUN;
        end else begin
          rst_cnt_d = rst_cnt_q + RC_W'(1);
        end
      end
      ST_RUN: begin
        if (enter_complete) begin
          state_d   = ST_COMPLETE;
        end else if (enter_abort) begin
          state_d   = ST_ABORT;
          rst_cnt_d = '0;
        end
      end
      ST_COMPLETE: begin
        state_d = ST_IDLE;
      end
      ST_ABORT: begin
        if (rst_cnt_q == RC_LAST) begin
          state_d = ST_IDLE;
        end else begin
          rst_cnt_d = rst_cnt_q + RC_W'(1);
        end
      end
      default: begin
        state_d   = ST_IDLE;
        rst_cnt_d = '0;
      end
    endcase

    dispatch_reset_d = (state_d == ST_CLEAR) || (state_d == ST_ABORT);
    dispatch_start_d = (state_d == ST_RUN);
    busy_d           = (state_d == ST_CLEAR) || (state_d == ST_RUN) || (state_d == ST_ABORT);
    irq_d            = (state_d == ST_COMPLETE);
  end

  // State register and reset-window counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      rst_cnt_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      state_q   <= state_d;
      rst_cnt_q <= rst_cnt_d;
    end
  end

  // Registered dispatcher controls; dispatch_reset is held high while in reset so the
  // dispatcher stays quiesced, and drops on the first clock after release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dispatch_reset_q <= 1'b1;
      dispatch_start_q <= 1'b0;
      busy_q           <= 1'b0;
      irq_q            <= 1'b0;
    end else begin
      dispatch_reset_q <= dispatch_reset_d;
      dispatch_start_q <= dispatch_start_d;
      busy_q           <= busy_d;
      irq_q            <= irq_d;
    end
  end

  // Thread count register: host writable only while the controller is not busy
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      thread_count_q <= '0;
    end else if (wr_thread_count && !busy_now) begin
      thread_count_q <= THREAD_COUNT_BITS'(reg_write_data);
    end
  end

  // Sticky status flags: clear_status and a successful launch clear, events set; a set
  // arriving in the same cycle as a clear wins so no event is lost.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      done_q     <= 1'b0;
      aborted_q  <= 1'b0;
      err_busy_q <= 1'b0;
      err_zero_q <= 1'b0;
    end else begin
      if (cmd_clear) begin
        done_q     <= 1'b0;
        aborted_q  <= 1'b0;
        err_busy_q <= 1'b0;
        err_zero_q <= 1'b0;
      end
      if (launch_ok) begin
        done_q    <= 1'b0;
        aborted_q <= 1'b0;
      end
      if (enter_complete) begin
        done_q <= 1'b1;
      end
      if (enter_abort) begin
        aborted_q <= 1'b1;
      end
      if (busy_violation) begin
        err_busy_q <= 1'b1;
      end
      if (launch_zero) begin
        err_zero_q <= 1'b1;
      end
    end
  end

  // Kernel cycle counter: restarts on launch, counts CLEAR and RUN cycles, saturates
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycle_count_q <= '0;
    end else if (launch_ok) begin
      cycle_count_q <= '0;
    end else if (((state_q == ST_CLEAR) || (state_q == ST_RUN)) && (cycle_count_q != '1)) begin
      cycle_count_q <= cycle_count_q + CYCLE_COUNT_BITS'(1);
    end
  end

  assign status_byte = {3'b000, err_zero_q, err_busy_q, aborted_q, done_q, busy_q};

  // Read multiplexer; it sees pre-write register values, so a read and write to the
  // same address in one cycle return the old contents.
  always_comb begin
    read_mux = '0;
    unique case (reg_addr)
      ADDR_THREAD_COUNT: read_mux = 8'(thread_count_q);
      ADDR_CONTROL:      read_mux = '0;
      ADDR_STATUS:       read_mux = status_byte;
      ADDR_CYCLES:       read_mux = 8'(cycle_count_q);
      default:           read_mux = '0;
    endcase
  end

  // Host read port with one cycle of latency
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      read_data_q  <= '0;
      read_valid_q <= 1'b0;
    end else begin
      read_valid_q <= reg_read_en;
      if (reg_read_en) begin
        read_data_q <= read_mux;
      end
    end
  end

  assign reg_read_data  = read_data_q;
  assign reg_read_valid = read_valid_q;
  assign thread_count   = thread_count_q;
  assign dispatch_reset = dispatch_reset_q;
  assign dispatch_start = dispatch_start_q;
  assign busy           = busy_q;
  assign irq            = irq_q;
  assign cycle_count    = cycle_count_q;

endmodule
